// File: rtl/osc_tick_pkg.sv
// Shared types and default parameter values for the oscillator tick generator.
package osc_tick_pkg;

  // Top-level sequencing of the oscillator enable.
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } osc_state_t;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_DIV_W         = 16;
  localparam int DEF_WARMUP_CYCLES = 256;

endpackage

// File: rtl/osc_tick_ch.sv
// One tick channel: period down-counter, pending divisor and the logic that
// decides when a newly programmed divisor may take over without disturbing
// the period already in progress.
module osc_tick_ch #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,         // top FSM is in RUN this cycle
  input  logic             run_nxt,     // top FSM will be in RUN next cycle
  input  logic             load,
  input  logic [DIV_W-1:0] cfg,
  output logic             tick,
  output logic [DIV_W-1:0] div_active
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend;
  logic             pend_vld;

  logic             pv;
  logic [DIV_W-1:0] pv_val;
  logic             boundary;
  logic             apply;
  logic [DIV_W-1:0] d_nxt;
  logic [DIV_W-1:0] cnt_nxt;

  // Counter start value for a period of d cycles; a disabled channel (d = 0)
  // parks its counter at zero.
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  // Next divisor and counter value. A load in the same cycle as a period
  // boundary bypasses the pending register so the fresh value wins. Outside
  // RUN the counter is always zero, so the cnt == 0 test also covers the
  // "not running" and "disabled" cases where a pending value applies at once.
  always_comb begin
    pv       = load | pend_vld;
    pv_val   = load ? cfg : pend;
    boundary = !run || (cnt == '0);
    apply    = pv && boundary;
    d_nxt    = apply ? pv_val : div_active;
    if (!run_nxt) begin
      cnt_nxt = '0;
    end else if (boundary) begin
      cnt_nxt = reload_val(d_nxt);
    end else begin
      cnt_nxt = cnt - DIV_W'(1);
    end
  end

  // Control state and registered outputs; tick is derived from the values the
  // counter and divisor will hold next cycle so it leaves a flop directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      pend_vld   <= 1'b0;
      tick       <= 1'b0;
      div_active <= DIV_W'(1);
    end else begin
      cnt        <= cnt_nxt;
      pend_vld   <= pv && !apply;
      tick       <= run_nxt && (cnt_nxt == '0) && (d_nxt != '0);
      div_active <= d_nxt;
    end
  end

  // Pending divisor data; only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    if (load) begin
      pend <= cfg;
    end
  end

endmodule

// File: rtl/osc_tick_gen.sv
// Oscillator-driven tick generator: waits for the oscillator to settle after
// enable, then emits per-channel clock-enable pulses at programmable divisors.
module osc_tick_gen
  import osc_tick_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int DIV_W         = DEF_DIV_W,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    osc_en,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic [NUM_CH-1:0]       div_load,
  output logic                    ready,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*DIV_W-1:0] div_active
);

  localparam int WARM_W = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES + 1);

  osc_state_t  state;
  logic [WARM_W-1:0] warm;
  logic        run;
  logic        run_nxt;

  // The warm counter is loaded with WARMUP_CYCLES and RUN is entered on the
  // step that takes it to zero, so ready rises WARMUP_CYCLES+1 cycles after
  // enable is seen. With WARMUP_CYCLES = 0 one WARMUP cycle is still spent.
  assign run     = (state == ST_RUN);
  assign run_nxt = !rst && osc_en &&
                   ((state == ST_RUN) || ((state == ST_WARMUP) && (warm <= WARM_W'(1))));

  // Top FSM with warm-up counter; losing osc_en returns to OFF from anywhere.
  always_ff @(posedge clk) begin
    if (rst || !osc_en) begin
      state <= ST_OFF;
      warm  <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state <= ST_WARMUP;
          warm  <= WARM_W'(WARMUP_CYCLES);
          ready <= 1'b0;
        end
        ST_WARMUP: begin
          if (warm <= WARM_W'(1)) begin
            state <= ST_RUN;
            warm  <= '0;
            ready <= 1'b1;
          end else begin
            warm <= warm - WARM_W'(1);
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= ST_OFF;
          warm  <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    osc_tick_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .run_nxt    (run_nxt),
      .load       (div_load[k]),
      .cfg        (div_cfg[k*DIV_W +: DIV_W]),
      .tick       (tick[k]),
      .div_active (div_active[k*DIV_W +: DIV_W])
    );
  end

endmodule

// File: tb/tb_osc_tick_gen.sv
// Scoreboard bench for osc_tick_gen: the driver runs a behavioural model in
// step with the stimulus and queues the expected outputs; a monitor on the
// falling edge pops and compares.
module tb_osc_tick_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int WARMUP = 4;
  localparam int WMIN   = (WARMUP == 0) ? 1 : WARMUP;

  logic                    clk;
  logic                    rst;
  logic                    osc_en;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic [NUM_CH-1:0]       div_load;
  logic                    ready;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH*DIV_W-1:0] div_active;

  osc_tick_gen #(
    .NUM_CH        (NUM_CH),
    .DIV_W         (DIV_W),
    .WARMUP_CYCLES (WARMUP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .osc_en     (osc_en),
    .div_cfg    (div_cfg),
    .div_load   (div_load),
    .ready      (ready),
    .tick       (tick),
    .div_active (div_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                      cyc;
    string                   tag;
    logic                    ready;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*DIV_W-1:0] div;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  string phase = "reset";

  // Reference model: mode 0=off 1=warm 2=run; age is the 1-based position
  // within the current period, a tick falls on age == D.
  int m_mode;
  int m_wc;
  int m_D[NUM_CH];
  int m_pend[NUM_CH];
  bit m_pv[NUM_CH];
  int m_age[NUM_CH];

  logic                    en_v  = 1'b0;
  logic [NUM_CH*DIV_W-1:0] cfg_v = '0;

  function automatic bit mtick(input int k);
    return (m_mode == 2) && (m_D[k] != 0) && (m_age[k] == m_D[k]);
  endfunction

  task automatic model_step(input bit r, input bit en, input logic [NUM_CH-1:0] ld,
                            input logic [NUM_CH*DIV_W-1:0] cfg);
    bit prev_run;
    bit now_run;
    bit tk[NUM_CH];
    bit bnd;
    if (r) begin
      m_mode = 0;
      m_wc   = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_D[k] = 1; m_pv[k] = 1'b0; m_age[k] = 0;
      end
    end else begin
      prev_run = (m_mode == 2);
      for (int k = 0; k < NUM_CH; k++) tk[k] = mtick(k);
      if (!en) begin
        m_mode = 0; m_wc = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_wc = 1;
      end else if (m_mode == 1) begin
        if (m_wc >= WMIN) m_mode = 2;
        else m_wc++;
      end
      now_run = (m_mode == 2);
      for (int k = 0; k < NUM_CH; k++) begin
        bnd = !prev_run || (m_D[k] == 0) || tk[k];
        if (ld[k]) begin
          m_pend[k] = int'(cfg[k*DIV_W +: DIV_W]);
          m_pv[k]   = 1'b1;
        end
        if (bnd && m_pv[k]) begin
          m_D[k]  = m_pend[k];
          m_pv[k] = 1'b0;
        end
        if (!now_run) m_age[k] = 0;
        else if (bnd) m_age[k] = 1;
        else m_age[k]++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cyc   = cyc;
    e.tag   = phase;
    e.ready = (m_mode == 2);
    for (int k = 0; k < NUM_CH; k++) begin
      e.tick[k] = mtick(k);
      e.div[k*DIV_W +: DIV_W] = DIV_W'(m_D[k]);
    end
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show after it.
  task automatic step(input bit r, input logic [NUM_CH-1:0] ld);
    exp_t e;
    rst      = r;
    osc_en   = en_v;
    div_load = ld;
    div_cfg  = cfg_v;
    model_step(r, en_v, ld, cfg_v);
    cyc++;
    e = model_out();
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic set_cfg(input int k, input int v);
    cfg_v[k*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  // Monitor: every DUT cycle has one queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (ready !== e.ready || tick !== e.tick || div_active !== e.div) begin
        n_bad++;
        $display("FAIL cyc%0d %s: got ready=%0b tick=%b div=%h, expected ready=%0b tick=%b div=%h",
                 e.cyc, e.tag, ready, tick, div_active, e.ready, e.tick, e.div);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    rst = 1'b1; osc_en = 1'b0; div_load = '0; div_cfg = '0;
    @(posedge clk); #1;

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, '0);
    idle(3);

    phase = "warmup_default_div";
    en_v = 1'b1;
    idle(14);

    phase = "off_load_d3";
    en_v = 1'b0;
    idle(2);
    set_cfg(0, 3);
    step(1'b0, 4'b0001);
    en_v = 1'b1;
    idle(16);

    phase = "load_on_reload_d1";
    set_cfg(1, 3);
    step(1'b0, 4'b0010);
    idle(8);

    phase = "d5_then_d2";
    set_cfg(0, 5);
    step(1'b0, 4'b0001);
    idle(12);
    guard = 0;
    while (!mtick(0) && guard < 20) begin
      step(1'b0, '0);
      guard++;
    end
    step(1'b0, '0);
    step(1'b0, '0);
    set_cfg(0, 2);
    step(1'b0, 4'b0001);
    idle(12);

    phase = "disable_ch2";
    set_cfg(2, 0);
    step(1'b0, 4'b0100);
    idle(10);
    set_cfg(2, 4);
    step(1'b0, 4'b0100);
    idle(14);

    phase = "drop_enable";
    en_v = 1'b0;
    idle(3);
    en_v = 1'b1;
    idle(10);

    phase = "rst_in_warmup";
    en_v = 1'b0;
    idle(2);
    en_v = 1'b1;
    idle(2);
    step(1'b1, '0);
    idle(8);

    phase = "rst_in_run_pending";
    set_cfg(0, 9); set_cfg(1, 7); set_cfg(2, 6); set_cfg(3, 8);
    step(1'b0, 4'b1111);
    idle(3);
    set_cfg(0, 2); set_cfg(3, 3);
    step(1'b0, 4'b1001);
    step(1'b1, '0);
    idle(10);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      logic [NUM_CH-1:0] ld;
      bit r;
      r = ($urandom_range(0, 299) == 0);
      if (en_v && $urandom_range(0, 99) == 0) en_v = 1'b0;
      else if (!en_v && $urandom_range(0, 5) == 0) en_v = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        set_cfg(k, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 11)));
        ld[k] = ($urandom_range(0, 11) == 0);
      end
      step(r, ld);
    end

    idle(4);
    for (int i = 0; i < 5; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left in queue, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
